// File: rtl/multi_blink_timer.sv
// Multi-channel LED blink timer with a programmable period per channel.
// Each channel runs in one of four modes: stop, toggle, pulse or one-shot.
module multi_blink_timer #(
  parameter int unsigned N_CH           = 4,
  parameter int unsigned CNT_W          = 26,
  parameter int unsigned DEFAULT_PERIOD = 49999999,
  parameter int unsigned CH_W           = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2*N_CH-1:0] mode,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_period,
  output logic [N_CH-1:0]   led,
  output logic [N_CH-1:0]   tick,
  output logic [N_CH-1:0]   done
);

  localparam logic [CNT_W-1:0] PER_RST = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    MODE_STOP    = 2'b00,
    MODE_TOGGLE  = 2'b01,
    MODE_PULSE   = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_q, per_d;
    mode_e            mode_q, mode_d;
    mode_e            mode_i;
    logic             led_q, led_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic             wr_hit;
    logic             term;

    // Out-of-range channel numbers never match any channel index.
    assign wr_hit = wr_en && (wr_ch == CH_W'(i));
    assign mode_i = mode_e'(mode[2*i +: 2]);
    assign term   = (cnt_q == per_q);

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt_q  <= '0;
        per_q  <= PER_RST;
        mode_q <= MODE_STOP;
        led_q  <= 1'b0;
        tick_q <= 1'b0;
        done_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        per_q  <= per_d;
        mode_q <= mode_d;
        led_q  <= led_d;
        tick_q <= tick_d;
        done_q <= done_d;
      end
    end

    // Priority: period write, then mode change, then the mode's normal action.
    always_comb begin
      cnt_d  = cnt_q;
      per_d  = per_q;
      mode_d = mode_q;
      led_d  = led_q;
      tick_d = 1'b0;
      done_d = done_q;
      if (wr_hit) begin
        per_d  = wr_period;
        cnt_d  = '0;
        done_d = 1'b0;
        if (mode_q == MODE_PULSE) led_d = 1'b0;
      end else if (mode_i != mode_q) begin
        mode_d = mode_i;
        cnt_d  = '0;
        led_d  = 1'b0;
        done_d = 1'b0;
      end else begin
        case (mode_q)
          MODE_STOP: begin
            cnt_d  = '0;
            led_d  = 1'b0;
            done_d = 1'b0;
          end
          MODE_TOGGLE: begin
            if (term) begin
              cnt_d  = '0;
              tick_d = 1'b1;
              led_d  = ~led_q;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
          MODE_PULSE: begin
            if (term) begin
              cnt_d  = '0;
              tick_d = 1'b1;
              led_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
              led_d = 1'b0;
            end
          end
          MODE_ONESHOT: begin
            // Once fired, the counter parks at per until re-armed.
            if (done_q) begin
              led_d = 1'b1;
            end else if (term) begin
              tick_d = 1'b1;
              led_d  = 1'b1;
              done_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
          default: begin
            cnt_d = '0;
          end
        endcase
      end
    end

    assign led[i]  = led_q;
    assign tick[i] = tick_q;
    assign done[i] = done_q;
  end

endmodule

// File: tb/tb_multi_blink_timer.sv
// Directed self-checking bench for multi_blink_timer (3 channels, 8-bit counters, default period 7).
module tb_multi_blink_timer;
  localparam int unsigned N_CH  = 3;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned DEF_P = 7;
  localparam int unsigned CH_W  = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [2*N_CH-1:0] mode = '0;
  logic              wr_en = 1'b0;
  logic [CH_W-1:0]   wr_ch = '0;
  logic [CNT_W-1:0]  wr_period = '0;
  logic [N_CH-1:0]   led;
  logic [N_CH-1:0]   tick;
  logic [N_CH-1:0]   done;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  multi_blink_timer #(
    .N_CH(N_CH),
    .CNT_W(CNT_W),
    .DEFAULT_PERIOD(DEF_P),
    .CH_W(CH_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .mode(mode),
    .wr_en(wr_en),
    .wr_ch(wr_ch),
    .wr_period(wr_period),
    .led(led),
    .tick(tick),
    .done(done)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] p);
    wr_en     = 1'b1;
    wr_ch     = ch;
    wr_period = p;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    // Reset state
    #1 reset = 1'b1;
    #1;
    chk("rst_led", 32'(led), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_done", 32'(done), 0);
    step();
    step();
    reset = 1'b0;
    chk("rst_led2", 32'(led), 0);

    // Channel 0 toggle, P=3
    wr(0, 8'd3);
    mode[1:0] = 2'b01;
    step();
    chk("t1_start_tick", 32'(tick[0]), 0);
    chk("t1_start_led", 32'(led[0]), 0);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("t1_tick0", 32'(tick[0]), 32'(k % 4 == 0));
      chk("t1_led0", 32'(led[0]), 32'((k / 4) % 2));
      chk("t1_idle", 32'({led[2:1], tick[2:1]}), 0);
    end

    // Channel 1 pulse, P=2
    wr(1, 8'd2);
    mode[3:2] = 2'b10;
    step();
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("t2_tick1", 32'(tick[1]), 32'(k % 3 == 0));
      chk("t2_led1", 32'(led[1]), 32'(k % 3 == 0));
      chk("t2_done1", 32'(done[1]), 0);
    end

    // Channel 2 one-shot, P=5, then re-arm with P=1
    wr(2, 8'd5);
    mode[5:4] = 2'b11;
    step();
    for (int k = 1; k <= 60; k++) begin
      step();
      chk("t3_tick2", 32'(tick[2]), 32'(k == 6));
      chk("t3_led2", 32'(led[2]), 32'(k >= 6));
      chk("t3_done2", 32'(done[2]), 32'(k >= 6));
    end
    wr(2, 8'd1);
    chk("t3_rearm_done", 32'(done[2]), 0);
    chk("t3_rearm_tick", 32'(tick[2]), 0);
    chk("t3_rearm_led", 32'(led[2]), 1);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("t3b_tick2", 32'(tick[2]), 32'(k == 2));
      chk("t3b_done2", 32'(done[2]), 32'(k >= 2));
      chk("t3b_led2", 32'(led[2]), 1);
    end

    // Write colliding with terminal count, then out-of-range channel write
    wr(0, 8'd3);
    step();
    step();
    step();
    chk("t4_pre_tick", 32'(tick[0]), 0);
    wr(0, 8'd3);
    chk("t4_collide_tick", 32'(tick[0]), 0);
    for (int k = 1; k <= 12; k++) begin
      if (k == 6) begin
        wr_en     = 1'b1;
        wr_ch     = 2'd3;
        wr_period = 8'd0;
      end
      step();
      wr_en = 1'b0;
      chk("t4_tick0", 32'(tick[0]), 32'(k % 4 == 0));
    end
    chk("t4_done2_kept", 32'(done[2]), 1);

    // P=0 toggle; write and mode change in the same cycle
    mode[1:0] = 2'b00;
    step();
    chk("t6_stop_led", 32'(led[0]), 0);
    chk("t6_stop_tick", 32'(tick[0]), 0);
    mode[1:0] = 2'b01;
    wr(0, 8'd0);
    chk("t6_wr_tick", 32'(tick[0]), 0);
    chk("t6_wr_led", 32'(led[0]), 0);
    step();
    chk("t6_mchg_tick", 32'(tick[0]), 0);
    chk("t6_mchg_led", 32'(led[0]), 0);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("t6_tick0", 32'(tick[0]), 1);
      chk("t6_led0", 32'(led[0]), 32'(k % 2));
    end
    mode[1:0] = 2'b00;
    step();
    chk("t6_off_led", 32'(led[0]), 0);
    chk("t6_off_tick", 32'(tick[0]), 0);
    step();
    chk("t6_off_led2", 32'(led[0]), 0);
    chk("t6_off_tick2", 32'(tick[0]), 0);

    // Full-scale period wraps with a tick
    wr(1, 8'd255);
    chk("wrap_wr_led", 32'(led[1]), 0);
    chk("wrap_wr_tick", 32'(tick[1]), 0);
    for (int k = 1; k <= 512; k++) begin
      step();
      chk("wrap_tick1", 32'(tick[1]), 32'(k % 256 == 0));
      chk("wrap_led1", 32'(led[1]), 32'(k % 256 == 0));
    end

    // Asynchronous reset mid-count, then default period
    wr(0, 8'd3);
    mode[1:0] = 2'b01;
    step();
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("t5_tick0", 32'(tick[0]), 32'(k == 4));
    end
    chk("t5_led0_on", 32'(led[0]), 1);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_led", 32'(led), 0);
    chk("t5_async_tick", 32'(tick), 0);
    chk("t5_async_done", 32'(done), 0);
    step();
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("t5_tick", 32'(tick), (k == 9) ? 32'h7 : 32'h0);
      chk("t5_led", 32'(led), 32'({k >= 9, k == 9, k >= 9}));
      chk("t5_done", 32'(done), 32'({k >= 9, 2'b00}));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multi_blink_timer.md
Name: multi_blink_timer

Overview:
- Parametrised, multi-channel successor to the single LED-blink counter/terminal-check/toggle chain.
- Each channel holds a programmable period register, a free-running counter, a mode and a registered LED output.
- Sits between CLOCK_50 and the LEDG bank in the top level.
- Period words are written over a simple single-cycle write port, so one block drives several LEDs at independent rates.

Parameters:
- N_CH, 4, number of independent channels (1..16).
- CNT_W, 26, counter/period width in bits.
- DEFAULT_PERIOD, 49999999, reset value of every period register (terminal count P; the period is P+1 clock cycles).
- CH_W, 2, width of wr_ch; must be at least ceil(log2(N_CH)), with a minimum of 1.

Ports:
- clock  in  1  system clock (CLOCK_50 at top level).
- reset  in  1  asynchronous, active-high reset.
- mode  in  2*N_CH  per-channel mode; bits [2i+1:2i] belong to channel i.
- wr_en  in  1  period write strobe, sampled on the rising clock edge.
- wr_ch  in  CH_W  target channel of the write.
- wr_period  in  CNT_W  new terminal count P.
- led  out  N_CH  registered LED drive per channel.
- tick  out  N_CH  registered one-cycle terminal-count pulse per channel.
- done  out  N_CH  one-shot completion flag per channel.

Behaviour:
Reset (asynchronous, immediate):
- All counters = 0.
- All period registers = DEFAULT_PERIOD.
- led, tick, done = 0.
- Internal registered copy of mode (mode_q) = 0.

Per-channel state:
- cnt[CNT_W], per[CNT_W], mode_q[2], led, tick, done.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Evaluation order at each rising edge, per channel, highest priority first:
1. Write hit (wr_en=1 and wr_ch==i):
   - per<=wr_period, cnt<=0, tick<=0, done<=0.
   - led is unchanged, except in mode 10, where led<=0.
   - wr_ch >= N_CH is ignored by all channels.
2. Mode change (mode_i != mode_q):
   - mode_q<=mode_i, cnt<=0, led<=0, tick<=0, done<=0.
3. Normal operation, by mode_q:
   - 00 STOP: cnt<=0, led<=0, tick<=0, done<=0.
   - 01 TOGGLE:
     - If cnt==per: cnt<=0, tick<=1, led<=~led.
     - Else: cnt<=cnt+1, tick<=0.
   - 10 PULSE:
     - If cnt==per: cnt<=0, tick<=1, led<=1.
     - Else: cnt<=cnt+1, tick<=0, led<=0.
     - led therefore equals tick.
   - 11 ONESHOT:
     - If done=1: cnt holds, tick<=0, led holds 1.
     - Else if cnt==per: tick<=1, led<=1, done<=1, cnt holds at per.
     - Else: cnt<=cnt+1, tick<=0.
     - Re-arming requires a write hit or a mode change.

Timing:
- tick is high for exactly one cycle, on the cycle after the edge where cnt==per.
- After a counter restart (reset, write hit or mode change), the first tick is high during cycle P+1, counting cycle 0 as the first cycle with cnt=0.
- In steady state, the tick period is P+1 cycles.
- For TOGGLE, the led period is 2*(P+1) cycles.

Boundary conditions:
- P=0:
  - TOGGLE: tick is high continuously and led toggles every cycle.
  - PULSE: led is high continuously.
  - ONESHOT: done is set on the first normal cycle.
- P = 2^CNT_W-1: cnt reaches all-ones, then wraps to 0 with a tick. There is no overflow beyond per.
- A period write lowering per below the current cnt is harmless, because the write clears cnt.
- Write and mode change in the same cycle: the write applies, and mode_q is NOT updated. The mode change is therefore processed on the next edge, which clears cnt again.
- Write and terminal count in the same cycle: the write wins and no tick is issued.
- Reset mid-count returns the channel to its reset state asynchronously. The first tick after release follows the default period.
- Counter arithmetic is unsigned, CNT_W bits. The equality compare is against per only.

Test Plan:
1. Reset, write P=3 to channel 0, mode0=01, other channels 00 -> tick[0] high one cycle every 4 cycles; led[0] toggles on each tick (8-cycle period); led/tick[3:1] stay 0.
2. Channel 1 mode=10, P=2 -> led[1]==tick[1] at every cycle, high one cycle in every 3; done[1]=0 throughout.
3. Channel 2 mode=11, P=5 -> single tick[2] pulse in cycle 6; led[2]=1 and done[2]=1 thereafter for 50+ cycles. Rewrite P=1 -> done clears, tick again after 2 cycles, then holds.
4. Channel 0 at cnt=2 with P=3, write P=3 in the same cycle cnt would reach 3 -> no tick that cycle, cnt restarts, next tick 4 cycles later; write with wr_ch=3 while N_CH=3 -> no channel affected.
5. Assert reset mid-count with led[0]=1 -> led, tick, done are 0 immediately, without waiting for an edge; per[*]=DEFAULT_PERIOD. After release with mode 01 and default P, first tick after 50000000 cycles (checked with CNT_W=26 in a long run or by forcing the default to 7 in a short run).
6. P=0 in TOGGLE mode -> tick constantly 1, led alternates every cycle; switch mode to 00 -> next edge led=0, tick=0, cnt=0.
